soc_imem_loader: RTL and testbench

SOC_IMEM_LOADER -- requirements
Module: soc_imem_loader

---
 rtl/soc_pkg.sv | 44 ++++
 rtl/soc_imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_soc_imem_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// soc_pkg: shared register map, CTRL/STATUS bit positions and FSM state
// encodings for the IMEM loader.
package soc_pkg;

    // Register offsets, decoded from bus_addr[2:0] (byte address [4:2])
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PTR    = 3'd1;
    localparam logic [2:0] OFF_DATA   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_CHKSUM = 3'd4;

    // CTRL bit positions
    localparam int CTRL_HOLD    = 0;
    localparam int CTRL_PTR_CLR = 1;

    // STATUS bit positions
    localparam int STAT_HOLD      = 0;
    localparam int STAT_ERR       = 1;
    localparam int STAT_RUN       = 2;
    localparam int STAT_COUNT_LSB = 16;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    typedef enum logic [1:0] {
        REL_HELD  = 2'd0,
        REL_DRAIN = 2'd1,
        REL_RUN   = 2'd2
    } rel_state_t;

    // Byte-strobe merge of new write data over an old register image
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++)
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/soc_imem_loader.sv
// soc_imem_loader: bus-slave that streams a program image into IMEM while
// holding the CPU in reset, then releases the CPU after a drain delay.
// Optional feature: define SOC_IMEM_LOADER_CHKSUM_EN to add a running
// 32-bit checksum of accepted image words at offset 4.
module soc_imem_loader
    import soc_pkg::*;
#(
    parameter int unsigned NUM_WORDS_IMEM = 8192,
    parameter int unsigned RELEASE_DLY    = 4,
    parameter logic        HOLD_AT_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        bus_vld,
    output logic        bus_rdy,
    input  logic [3:0]  bus_we,
    input  logic [29:0] bus_addr,
    input  logic [31:0] bus_wdat,
    output logic [31:0] bus_rdat,
    output logic        imem_cpu_rstn,
    output logic        imem_we,
    output logic [29:0] imem_waddr,
    output logic [31:0] imem_wdat
);

    localparam int PW = $clog2(NUM_WORDS_IMEM);

    bus_state_t  bus_state, bus_next;
    rel_state_t  rel_state, rel_next;
    logic [3:0]  rel_cnt, rel_cnt_next;

    logic          hold, err;
    logic [PW-1:0] ptr;
    logic [15:0]   count;
    logic [31:0]   rd_mux, ptr_merged, chksum_rd;
    logic [2:0]    off;
    logic          start, is_wr, data_ok, data_err, ptr_clr;
    logic          unused_ok;

    assign off        = bus_addr[2:0];
    assign is_wr      = |bus_we;
    assign ptr_merged = byte_merge(32'(ptr), bus_wdat, bus_we);
    assign unused_ok  = ^{bus_addr[29:3], ptr_merged[31:PW]};

    // Every transaction commits on the edge entering ACK; these qualify it
    assign data_ok  = start && is_wr && off == OFF_DATA && hold && bus_we == 4'hF;
    assign data_err = start && is_wr && off == OFF_DATA && !data_ok;
    assign ptr_clr  = start && is_wr && off == OFF_CTRL && bus_we[0] && bus_wdat[CTRL_PTR_CLR];

    // Bus FSM state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) bus_state <= BUS_IDLE;
        else         bus_state <= bus_next;
    end

    // Bus FSM next state: ACK always returns to IDLE so a held bus_vld never double-commits
    always_comb begin
        bus_next = bus_state;
        start    = 1'b0;
        case (bus_state)
            BUS_IDLE: if (bus_vld) begin
                bus_next = BUS_ACK;
                start    = 1'b1;
            end
            BUS_ACK:  bus_next = BUS_IDLE;
            default:  bus_next = BUS_IDLE;
        endcase
    end

    assign bus_rdy = (bus_state == BUS_ACK);

    // Read mux; write-only and unmapped offsets read zero
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:   rd_mux[CTRL_HOLD] = hold;
            OFF_PTR:    rd_mux = 32'(ptr);
            OFF_STATUS: begin
                rd_mux[STAT_HOLD] = hold;
                rd_mux[STAT_ERR]  = err;
                rd_mux[STAT_RUN]  = imem_cpu_rstn;
                rd_mux[STAT_COUNT_LSB +: 16] = count;
            end
            OFF_CHKSUM: rd_mux = chksum_rd;
            default:    rd_mux = '0;
        endcase
    end

    // Register file, IMEM write port and registered read data
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hold       <= HOLD_AT_RESET;
            err        <= 1'b0;
            ptr        <= '0;
            count      <= '0;
            bus_rdat   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdat  <= '0;
        end else begin
            imem_we  <= 1'b0;
            bus_rdat <= '0;
            if (start && !is_wr) bus_rdat <= rd_mux;
            if (start && is_wr) begin
                case (off)
                    OFF_CTRL: if (bus_we[0]) begin
                        hold <= bus_wdat[CTRL_HOLD];
                        if (bus_wdat[CTRL_PTR_CLR]) begin
                            ptr   <= '0;
                            count <= '0;
                        end
                    end
                    OFF_PTR:    ptr <= ptr_merged[PW-1:0];
                    OFF_STATUS: if (bus_we[0] && bus_wdat[STAT_ERR]) err <= 1'b0;
                    default: ;
                endcase
            end
            if (data_ok) begin
                imem_we    <= 1'b1;
                imem_waddr <= 30'(ptr);
                imem_wdat  <= bus_wdat;
                ptr        <= ptr + PW'(1);
                if (count != 16'hFFFF) count <= count + 16'd1;
            end
            if (data_err) err <= 1'b1;
        end
    end

`ifdef SOC_IMEM_LOADER_CHKSUM_EN
    logic [31:0] chksum;

    // Running modulo-2^32 sum of accepted image words
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)      chksum <= '0;
        else if (ptr_clr) chksum <= '0;
        else if (data_ok) chksum <= chksum + bus_wdat;
    end

    assign chksum_rd = chksum;
`else
    assign chksum_rd = '0;
`endif

    // Release FSM and CPU reset output registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rel_state     <= REL_HELD;
            rel_cnt       <= '0;
            imem_cpu_rstn <= 1'b0;
        end else begin
            rel_state     <= rel_next;
            rel_cnt       <= rel_cnt_next;
            imem_cpu_rstn <= (rel_next == REL_RUN);
        end
    end

    // Release FSM next state: HOLD wins from any state, so re-asserting it
    // during DRAIN forces a fresh full-length count on the next release
    always_comb begin
        rel_next     = rel_state;
        rel_cnt_next = rel_cnt;
        if (hold) begin
            rel_next = REL_HELD;
        end else begin
            case (rel_state)
                REL_HELD: begin
                    rel_next     = REL_DRAIN;
                    rel_cnt_next = 4'(RELEASE_DLY);
                end
                REL_DRAIN: begin
                    rel_cnt_next = rel_cnt - 4'd1;
                    if (rel_cnt == 4'd1) rel_next = REL_RUN;
                end
                REL_RUN:  rel_next = REL_RUN;
                default:  rel_next = REL_HELD;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_imem_loader.sv
// tb_soc_imem_loader: directed vector table plus hand sequences for release
// timing, held bus_vld and reset during ACK.
module tb_soc_imem_loader;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        bus_vld;
    logic        bus_rdy;
    logic [3:0]  bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdat;
    logic [31:0] bus_rdat;
    logic        imem_cpu_rstn;
    logic        imem_we;
    logic [29:0] imem_waddr;
    logic [31:0] imem_wdat;

    int nvec  = 0;
    int nfail = 0;

`ifdef SOC_IMEM_LOADER_CHKSUM_EN
    localparam logic [31:0] CHK_EXP = 32'h21;
`else
    localparam logic [31:0] CHK_EXP = 32'h0;
`endif

    soc_imem_loader dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .bus_vld      (bus_vld),
        .bus_rdy      (bus_rdy),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdat     (bus_wdat),
        .bus_rdat     (bus_rdat),
        .imem_cpu_rstn(imem_cpu_rstn),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdat    (imem_wdat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  off;
        logic [3:0]  we;
        logic [31:0] wdat;
        logic [31:0] exp_rdat;
        logic        exp_we;
        logic [29:0] exp_waddr;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus transaction, driven at a negedge and ending at the ACK negedge
    task automatic xact(input logic [2:0] off, input logic [3:0] we, input logic [31:0] wdat,
                        output logic [31:0] rdat, output logic saw_we,
                        output logic [29:0] waddr, output logic [31:0] wd);
        logic done;
        @(negedge clk);
        bus_vld  = 1'b1;
        bus_addr = {27'd0, off};
        bus_we   = we;
        bus_wdat = wdat;
        rdat = '0; saw_we = 1'b0; waddr = '0; wd = '0; done = 1'b0;
        for (int n = 0; n < 8 && !done; n++) begin
            @(negedge clk);
            if (imem_we) begin
                saw_we = 1'b1;
                waddr  = imem_waddr;
                wd     = imem_wdat;
            end
            if (bus_rdy) begin
                rdat = bus_rdat;
                done = 1'b1;
            end
        end
        bus_vld = 1'b0;
        bus_we  = 4'h0;
        if (!done) chk("bus_rdy_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd, wd;
    logic        sw;
    logic [29:0] wa;

    initial begin
        arst_n = 1'b0; bus_vld = 1'b0; bus_we = '0; bus_addr = '0; bus_wdat = '0;

        //            off  we     wdat          exp_rdat      we    waddr
        vecs[0]  = '{3'd3, 4'h0, 32'h0,        32'h0000_0001, 1'b0, 30'd0};
        vecs[1]  = '{3'd0, 4'h0, 32'h0,        32'h0000_0001, 1'b0, 30'd0};
        vecs[2]  = '{3'd1, 4'h0, 32'h0,        32'h0,         1'b0, 30'd0};
        vecs[3]  = '{3'd1, 4'hF, 32'h1FFE,     32'h0,         1'b0, 30'd0};
        vecs[4]  = '{3'd1, 4'h0, 32'h0,        32'h1FFE,      1'b0, 30'd0};
        vecs[5]  = '{3'd2, 4'hF, 32'hA,        32'h0,         1'b1, 30'd8190};
        vecs[6]  = '{3'd2, 4'hF, 32'hB,        32'h0,         1'b1, 30'd8191};
        vecs[7]  = '{3'd2, 4'hF, 32'hC,        32'h0,         1'b1, 30'd0};
        vecs[8]  = '{3'd3, 4'h0, 32'h0,        32'h0003_0001, 1'b0, 30'd0};
        vecs[9]  = '{3'd4, 4'h0, 32'h0,        CHK_EXP,       1'b0, 30'd0};
        vecs[10] = '{3'd2, 4'h0, 32'h0,        32'h0,         1'b0, 30'd0};
        vecs[11] = '{3'd1, 4'h1, 32'hFFFF_FF05, 32'h0,        1'b0, 30'd0};
        vecs[12] = '{3'd1, 4'h0, 32'h0,        32'h5,         1'b0, 30'd0};
        vecs[13] = '{3'd1, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b0, 30'd0};
        vecs[14] = '{3'd1, 4'h0, 32'h0,        32'h1FFF,      1'b0, 30'd0};
        vecs[15] = '{3'd2, 4'h3, 32'hDEAD,     32'h0,         1'b0, 30'd0};
        vecs[16] = '{3'd3, 4'h0, 32'h0,        32'h0003_0003, 1'b0, 30'd0};
        vecs[17] = '{3'd3, 4'h1, 32'h2,        32'h0,         1'b0, 30'd0};
        vecs[18] = '{3'd3, 4'h0, 32'h0,        32'h0003_0001, 1'b0, 30'd0};
        vecs[19] = '{3'd5, 4'hF, 32'hFFFF_FFFF, 32'h0,        1'b0, 30'd0};
        vecs[20] = '{3'd5, 4'h0, 32'h0,        32'h0,         1'b0, 30'd0};
        vecs[21] = '{3'd0, 4'h2, 32'h2,        32'h0,         1'b0, 30'd0};
        vecs[22] = '{3'd1, 4'h0, 32'h0,        32'h1FFF,      1'b0, 30'd0};
        vecs[23] = '{3'd0, 4'hF, 32'h3,        32'h0,         1'b0, 30'd0};
        vecs[24] = '{3'd1, 4'h0, 32'h0,        32'h0,         1'b0, 30'd0};
        vecs[25] = '{3'd3, 4'h0, 32'h0,        32'h0000_0001, 1'b0, 30'd0};
        vecs[26] = '{3'd4, 4'h0, 32'h0,        32'h0,         1'b0, 30'd0};
        vecs[27] = '{3'd0, 4'h0, 32'h0,        32'h0000_0001, 1'b0, 30'd0};

        repeat (3) @(negedge clk);
        chk("reset_cpu_rstn", 32'(imem_cpu_rstn), 32'd0);
        chk("reset_bus_rdy", 32'(bus_rdy), 32'd0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            xact(vecs[i].off, vecs[i].we, vecs[i].wdat, rd, sw, wa, wd);
            chk($sformatf("v%0d_rdat", i), rd, vecs[i].exp_rdat);
            chk($sformatf("v%0d_imem_we", i), 32'(sw), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_waddr", i), 32'(wa), 32'(vecs[i].exp_waddr));
                chk($sformatf("v%0d_wdat", i), wd, vecs[i].wdat);
            end
        end

        // Release: CTRL=0, CPU reset rises 5 cycles after the ACK
        xact(3'd0, 4'hF, 32'h0, rd, sw, wa, wd);
        chk("rel_k0", 32'(imem_cpu_rstn), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) chk("rel_k4", 32'(imem_cpu_rstn), 32'd0);
            if (k == 5) chk("rel_k5", 32'(imem_cpu_rstn), 32'd1);
        end
        xact(3'd3, 4'h0, 32'h0, rd, sw, wa, wd);
        chk("status_run", rd, 32'h0000_0004);

        // DATA write while released is rejected and flags ERR
        xact(3'd2, 4'hF, 32'h1234, rd, sw, wa, wd);
        chk("nohold_imem_we", 32'(sw), 32'd0);
        xact(3'd3, 4'h0, 32'h0, rd, sw, wa, wd);
        chk("nohold_err", rd, 32'h0000_0006);
        xact(3'd3, 4'hF, 32'h2, rd, sw, wa, wd);
        xact(3'd3, 4'h0, 32'h0, rd, sw, wa, wd);
        chk("err_cleared", rd, 32'h0000_0004);

        // Hold: CTRL=1, CPU reset falls 1 cycle after the ACK
        xact(3'd0, 4'hF, 32'h1, rd, sw, wa, wd);
        chk("hold_k0", 32'(imem_cpu_rstn), 32'd1);
        @(negedge clk);
        chk("hold_k1", 32'(imem_cpu_rstn), 32'd0);

        // HOLD pulsed during DRAIN restarts the full count
        xact(3'd0, 4'hF, 32'h0, rd, sw, wa, wd);
        repeat (2) @(negedge clk);
        xact(3'd0, 4'hF, 32'h1, rd, sw, wa, wd);
        xact(3'd0, 4'hF, 32'h0, rd, sw, wa, wd);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) chk("restart_k4", 32'(imem_cpu_rstn), 32'd0);
            if (k == 5) chk("restart_k5", 32'(imem_cpu_rstn), 32'd1);
        end
        xact(3'd0, 4'hF, 32'h3, rd, sw, wa, wd);
        repeat (2) @(negedge clk);

        // bus_vld held for 6 cycles: one ACK and one IMEM write every other cycle
        @(posedge clk); #1;
        bus_vld = 1'b1; bus_addr = 30'd2; bus_we = 4'hF; bus_wdat = 32'h55;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("held_c%0d_rdy", c), 32'(bus_rdy), 32'(c % 2 == 0));
            chk($sformatf("held_c%0d_we", c), 32'(imem_we), 32'(c % 2 == 0));
        end
        bus_vld = 1'b0; bus_we = 4'h0;
        xact(3'd3, 4'h0, 32'h0, rd, sw, wa, wd);
        chk("held_count", rd, 32'h0003_0001);
        xact(3'd1, 4'h0, 32'h0, rd, sw, wa, wd);
        chk("held_ptr", rd, 32'h3);

        // Reset dropped in the ACK cycle of a DATA write discards it
        @(negedge clk);
        bus_vld = 1'b1; bus_addr = 30'd2; bus_we = 4'hF; bus_wdat = 32'h77;
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(negedge clk);
        chk("rst_ack_imem_we", 32'(imem_we), 32'd0);
        bus_vld = 1'b0; bus_we = 4'h0;
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_ack_quiet%0d", c), 32'(imem_we), 32'd0);
        end
        xact(3'd1, 4'h0, 32'h0, rd, sw, wa, wd);
        chk("rst_ack_ptr", rd, 32'h0);
        xact(3'd3, 4'h0, 32'h0, rd, sw, wa, wd);
        chk("rst_ack_status", rd, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
